// File: rtl/pixel_binner_2x2.sv
// 2x2 averaging binner for the MT9V034 pixel stream; index-based pairing, no stall.
// Define BINNING_ROUND_EN for round-half-up division, otherwise the divide truncates.
module pixel_binner_2x2 #(
   parameter int H = 752,
   parameter int V = 480
) (
   input  logic                    PIXCLK,
   input  logic                    RST,
   input  logic                    PIXEL_VALID,
   input  logic [9:0]              DATA_IN,
   input  logic [$clog2(V)-1:0]    LINE_IDX,
   input  logic [$clog2(H)-1:0]    COL_IDX,
   output logic                    OUT_VALID,
   output logic [9:0]              OUT_DATA,
   output logic [$clog2(V/2)-1:0]  OUT_LINE,
   output logic [$clog2(H/2)-1:0]  OUT_COL,
   output logic                    OUT_FRAME_START
);

   localparam int LW  = $clog2(V);
   localparam int CW  = $clog2(H);
   localparam int OLW = $clog2(V/2);
   localparam int OCW = $clog2(H/2);
   localparam int D   = H / 2;
   localparam int PW  = CW - 1;
   localparam int LPW = LW - 1;

   logic [9:0]     hold_q, hold_d;
   logic           pend_q, pend_d;
   logic [PW-1:0]  pidx_q, pidx_d;
   logic           primed_q, primed_d;
   logic [LPW-1:0] pline_q, pline_d;
   logic [10:0]    rd_q;
   logic [10:0]    mem [D];

   logic [PW-1:0]  col_pair;
   logic [LPW-1:0] line_pair;
   logic [OCW-1:0] addr;
   logic           frame_start, pend_eff, primed_eff;
   logic           in_range, pair_done, wr_en, rd_en, emit;
   logic [10:0]    psum;
   logic [11:0]    sum, sum_adj;

   assign col_pair    = COL_IDX[CW-1:1];
   assign line_pair   = LINE_IDX[LW-1:1];
   assign addr        = OCW'(col_pair);
   assign frame_start = PIXEL_VALID && (LINE_IDX == '0) && (COL_IDX == '0);
   assign pend_eff    = pend_q && !frame_start;
   assign primed_eff  = primed_q && !frame_start;
   assign in_range    = col_pair < PW'(D);

   assign pair_done = PIXEL_VALID && COL_IDX[0] && pend_eff &&
                      (col_pair == pidx_q);
   assign psum      = {1'b0, hold_q} + {1'b0, DATA_IN};
   assign wr_en     = pair_done && !LINE_IDX[0] && in_range;
   assign rd_en     = PIXEL_VALID && !COL_IDX[0] && LINE_IDX[0] && in_range;
   // primed_line mismatch covers skipped even lines and cross-frame reuse
   assign emit      = pair_done && LINE_IDX[0] && primed_eff &&
                      (pline_q == line_pair);
   assign sum       = {1'b0, rd_q} + {1'b0, psum};

`ifdef BINNING_ROUND_EN
   assign sum_adj = sum + 12'd2;
`else
   assign sum_adj = sum;
`endif

   always_comb begin
      hold_d   = hold_q;
      pend_d   = pend_eff;
      pidx_d   = pidx_q;
      primed_d = primed_eff;
      pline_d  = pline_q;
      if (PIXEL_VALID && !COL_IDX[0]) begin
         hold_d = DATA_IN;
         pend_d = 1'b1;
         pidx_d = col_pair;
      end
      if (pair_done) pend_d = 1'b0;
      if (wr_en) begin
         primed_d = 1'b1;
         pline_d  = line_pair;
      end
   end

   always_ff @(posedge PIXCLK) begin
      if (wr_en) mem[addr] <= psum;
      if (rd_en) rd_q <= mem[addr];
   end

   always_ff @(posedge PIXCLK) begin
      if (RST) begin
         hold_q          <= '0;
         pend_q          <= 1'b0;
         pidx_q          <= '0;
         primed_q        <= 1'b0;
         pline_q         <= '0;
         OUT_VALID       <= 1'b0;
         OUT_FRAME_START <= 1'b0;
         OUT_DATA        <= '0;
         OUT_LINE        <= '0;
         OUT_COL         <= '0;
      end else begin
         hold_q          <= hold_d;
         pend_q          <= pend_d;
         pidx_q          <= pidx_d;
         primed_q        <= primed_d;
         pline_q         <= pline_d;
         OUT_VALID       <= emit;
         OUT_FRAME_START <= emit && (line_pair == '0) && (col_pair == '0);
         if (emit) begin
            OUT_DATA <= sum_adj[11:2];
            OUT_LINE <= OLW'(line_pair);
            OUT_COL  <= addr;
         end
      end
   end

endmodule

// File: tb/tb_pixel_binner_2x2.sv
// Directed bench for pixel_binner_2x2; binned pulses are logged at negedge.
module tb_pixel_binner_2x2;

   logic       PIXCLK = 1'b0;
   logic       RST = 1'b1;
   logic       PIXEL_VALID = 1'b0;
   logic [9:0] DATA_IN = '0;
   logic [8:0] LINE_IDX = '0;
   logic [9:0] COL_IDX = '0;
   logic       OUT_VALID;
   logic [9:0] OUT_DATA;
   logic [7:0] OUT_LINE;
   logic [8:0] OUT_COL;
   logic       OUT_FRAME_START;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [7:0] l;
      logic [8:0] c;
      logic [9:0] d;
      logic       fs;
   } ev_t;

   ev_t evq[$];

   pixel_binner_2x2 dut (
      .PIXCLK          (PIXCLK),
      .RST             (RST),
      .PIXEL_VALID     (PIXEL_VALID),
      .DATA_IN         (DATA_IN),
      .LINE_IDX        (LINE_IDX),
      .COL_IDX         (COL_IDX),
      .OUT_VALID       (OUT_VALID),
      .OUT_DATA        (OUT_DATA),
      .OUT_LINE        (OUT_LINE),
      .OUT_COL         (OUT_COL),
      .OUT_FRAME_START (OUT_FRAME_START)
   );

   always #5 PIXCLK = ~PIXCLK;

   always @(negedge PIXCLK)
      if (OUT_VALID === 1'b1)
         evq.push_back({OUT_LINE, OUT_COL, OUT_DATA, OUT_FRAME_START});

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pix(input int l, input int c, input int d);
      @(negedge PIXCLK);
      PIXEL_VALID = 1'b1;
      LINE_IDX    = 9'(l);
      COL_IDX     = 10'(c);
      DATA_IN     = 10'(d);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge PIXCLK);
         PIXEL_VALID = 1'b0;
      end
   endtask

   task automatic line(input int l, input int w, input int d);
      for (int c = 0; c < w; c++) pix(l, c, d);
   endtask

   task automatic frame(input int w, input int h, input int d);
      for (int l = 0; l < h; l++) line(l, w, d);
      idle(3);
   endtask

   task automatic chk_ev(input string tag, input int i, input int l,
                         input int c, input int d, input int fs);
      if (evq.size() > i) begin
         chk({tag, "_line"}, 32'(evq[i].l), 32'(l));
         chk({tag, "_col"},  32'(evq[i].c), 32'(c));
         chk({tag, "_data"}, 32'(evq[i].d), 32'(d));
         chk({tag, "_fs"},   32'(evq[i].fs), 32'(fs));
      end
   endtask

   initial begin
      int exp7;
`ifdef BINNING_ROUND_EN
      exp7 = 2;
`else
      exp7 = 1;
`endif
      repeat (3) @(negedge PIXCLK);
      chk("rst_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_fs",    32'(OUT_FRAME_START), 32'd0);
      chk("rst_data",  32'(OUT_DATA), 32'd0);
      chk("rst_line",  32'(OUT_LINE), 32'd0);
      chk("rst_col",   32'(OUT_COL), 32'd0);
      RST = 1'b0;
      idle(2);

      evq.delete();
      frame(4, 4, 512);
      chk("basic_count", 32'(evq.size()), 32'd4);
      chk_ev("basic0", 0, 0, 0, 512, 1);
      chk_ev("basic1", 1, 0, 1, 512, 0);
      chk_ev("basic2", 2, 1, 0, 512, 0);
      chk_ev("basic3", 3, 1, 1, 512, 0);

      evq.delete();
      pix(0, 0, 1); pix(0, 1, 1); pix(1, 0, 1); pix(1, 1, 2);
      idle(3);
      chk("round5_count", 32'(evq.size()), 32'd1);
      chk_ev("round5", 0, 0, 0, 1, 1);

      evq.delete();
      pix(0, 0, 1); pix(0, 1, 2); pix(1, 0, 2); pix(1, 1, 2);
      idle(3);
      chk("round7_count", 32'(evq.size()), 32'd1);
      chk_ev("round7", 0, 0, 0, exp7, 1);

      evq.delete();
      pix(0, 0, 1023); pix(0, 1, 1023); pix(1, 0, 1023); pix(1, 1, 1023);
      chk("lat_pre_valid", 32'(OUT_VALID), 32'd0);
      idle(1);
      chk("lat_valid", 32'(OUT_VALID), 32'd1);
      chk("lat_data",  32'(OUT_DATA), 32'd1023);
      chk("lat_fs",    32'(OUT_FRAME_START), 32'd1);
      idle(1);
      chk("lat_post_valid", 32'(OUT_VALID), 32'd0);
      chk("lat_post_fs",    32'(OUT_FRAME_START), 32'd0);
      chk("lat_hold_data",  32'(OUT_DATA), 32'd1023);
      idle(2);

      evq.delete();
      frame(5, 3, 100);
      chk("odd_count", 32'(evq.size()), 32'd2);
      chk_ev("odd0", 0, 0, 0, 100, 1);
      chk_ev("odd1", 1, 0, 1, 100, 0);

      evq.delete();
      line(0, 4, 200);
      pix(1, 0, 200);
      @(negedge PIXCLK);
      PIXEL_VALID = 1'b0;
      RST = 1'b1;
      @(negedge PIXCLK);
      RST = 1'b0;
      pix(1, 1, 200); pix(1, 2, 200); pix(1, 3, 200);
      idle(3);
      chk("rstmid_count", 32'(evq.size()), 32'd0);
      frame(4, 2, 300);
      chk("frameB_count", 32'(evq.size()), 32'd2);
      chk_ev("frameB0", 0, 0, 0, 300, 1);
      chk_ev("frameB1", 1, 0, 1, 300, 0);

      evq.delete();
      line(2, 4, 40);
      line(1, 4, 80);
      idle(3);
      chk("skip_count", 32'(evq.size()), 32'd0);
      line(3, 4, 80);
      idle(3);
      chk("pair1_count", 32'(evq.size()), 32'd2);
      chk_ev("pair1_0", 0, 1, 0, 60, 0);
      chk_ev("pair1_1", 1, 1, 1, 60, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
